// File: rtl/k_banked_rdata_mem.sv
// k_banked_rdata_mem: multi-bank linear-fill data memory.
// The producer fills bank 0 addresses 0..DEPTH-1, then bank 1, and so on,
// until every bank holds data. The consumer reads any (bank, address) pair
// with one cycle of latency. Out-of-range reads return 0 and flag an error.
module k_banked_rdata_mem #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 3200,
  parameter int NUM_BANKS = 24,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_rewind,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [BANK_W-1:0] o_wr_bank,
  output logic              o_bank_done,
  output logic              o_full,
  input  logic              i_rd_en,
  input  logic [BANK_W-1:0] i_rd_bank,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_err
);

  localparam int WORDS = NUM_BANKS * DEPTH;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [BANK_W-1:0] r_wr_bank;
  logic [BANK_W-1:0] w_wr_bank_nxt;
  logic              r_bank_done;
  logic              w_bank_done_nxt;
  logic              w_wr_acc;
  logic              w_rd_oor;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  logic [DATA_W-1:0] r_mem [WORDS];

  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_err;

  // Flatten (bank, address) into a single storage index.
  function automatic logic [IDX_W-1:0] flat_idx(input logic [BANK_W-1:0] b,
                                                input logic [ADDR_W-1:0] a);
    logic [31:0] v;
    v = 32'(b) * 32'(DEPTH) + 32'(a);
    return IDX_W'(v);
  endfunction

  // Rewind wins over a same-cycle write; a full memory refuses writes.
  assign w_wr_acc = i_wr_valid && (r_state == ST_FILLING) && !i_rewind;
  assign w_wr_idx = flat_idx(r_wr_bank, r_wr_addr);
  assign w_rd_idx = flat_idx(i_rd_bank, i_rd_addr);
  // Widened compares so non-power-of-two sizes are caught without wrap.
  assign w_rd_oor = (32'(i_rd_bank) >= 32'(NUM_BANKS)) ||
                    (32'(i_rd_addr) >= 32'(DEPTH));

  // Fill-pointer next state: advance address, roll into next bank, or stop when full.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_bank_nxt   = r_wr_bank;
    w_bank_done_nxt = 1'b0;
    if (i_rewind) begin
      w_state_nxt   = ST_FILLING;
      w_wr_addr_nxt = '0;
      w_wr_bank_nxt = '0;
    end else if (w_wr_acc) begin
      if (r_wr_addr != LAST_ADDR) begin
        w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
      end else begin
        w_wr_addr_nxt   = '0;
        w_bank_done_nxt = 1'b1;
        if (r_wr_bank != LAST_BANK) begin
          w_wr_bank_nxt = r_wr_bank + BANK_W'(1);
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
    end
  end

  // Fill-pointer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILLING;
      r_wr_addr   <= '0;
      r_wr_bank   <= '0;
      r_bank_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_bank_done <= w_bank_done_nxt;
    end
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  // Registered read port; samples old contents on a same-address write (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_err <= w_rd_oor;
        if (w_rd_oor) begin
          r_rd_data <= '0;
        end else begin
          r_rd_data <= r_mem[w_rd_idx];
        end
      end else begin
        r_rd_err <= 1'b0;
      end
    end
  end

  assign o_wr_ready  = (r_state == ST_FILLING);
  assign o_full      = (r_state == ST_FULL);
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_bank   = r_wr_bank;
  assign o_bank_done = r_bank_done;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_err    = r_rd_err;

endmodule

// File: tb/tb_k_banked_rdata_mem.sv
// Testbench for k_banked_rdata_mem: directed stimulus with a read scoreboard.
module tb_k_banked_rdata_mem;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: DEPTH=4, NUM_BANKS=3
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rewind;
  logic [1:0]  wr_addr;
  logic [1:0]  wr_bank;
  logic        bank_done;
  logic        full;
  logic        rd_en;
  logic [1:0]  rd_bank;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;

  // Second DUT: DEPTH=5, so a 3-bit address can exceed the range
  logic        d5_wr_valid;
  logic [31:0] d5_wr_data;
  logic        d5_wr_ready;
  logic        d5_rewind;
  logic [2:0]  d5_wr_addr;
  logic [1:0]  d5_wr_bank;
  logic        d5_bank_done;
  logic        d5_full;
  logic        d5_rd_en;
  logic [1:0]  d5_rd_bank;
  logic [2:0]  d5_rd_addr;
  logic [31:0] d5_rd_data;
  logic        d5_rd_valid;
  logic        d5_rd_err;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t q5[$];

  k_banked_rdata_mem #(.DATA_W(32), .DEPTH(4), .NUM_BANKS(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_rewind(rewind), .o_wr_addr(wr_addr), .o_wr_bank(wr_bank),
    .o_bank_done(bank_done), .o_full(full),
    .i_rd_en(rd_en), .i_rd_bank(rd_bank), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rd_err(rd_err)
  );

  k_banked_rdata_mem #(.DATA_W(32), .DEPTH(5), .NUM_BANKS(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(d5_wr_valid), .i_wr_data(d5_wr_data), .o_wr_ready(d5_wr_ready),
    .i_rewind(d5_rewind), .o_wr_addr(d5_wr_addr), .o_wr_bank(d5_wr_bank),
    .o_bank_done(d5_bank_done), .o_full(d5_full),
    .i_rd_en(d5_rd_en), .i_rd_bank(d5_rd_bank), .i_rd_addr(d5_rd_addr),
    .o_rd_data(d5_rd_data), .o_rd_valid(d5_rd_valid), .o_rd_err(d5_rd_err)
  );

  // Monitor: pop and compare each time a DUT presents a read result.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 data=%0h with no request outstanding", rd_data);
      end else begin
        e = q.pop_front();
        if (rd_data !== e.data || rd_err !== e.err) begin
          errors++;
          $display("FAIL rd_result: got data=%0h err=%0b expected data=%0h err=%0b",
                   rd_data, rd_err, e.data, e.err);
        end
      end
    end
    if (d5_rd_valid === 1'b1) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL rd5_unexpected: rd_valid=1 data=%0h with no request outstanding", d5_rd_data);
      end else begin
        e = q5.pop_front();
        if (d5_rd_data !== e.data || d5_rd_err !== e.err) begin
          errors++;
          $display("FAIL rd5_result: got data=%0h err=%0b expected data=%0h err=%0b",
                   d5_rd_data, d5_rd_err, e.data, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] b, input logic [1:0] a, input logic [31:0] exp_d);
    rd_en   = 1'b1;
    rd_bank = b;
    rd_addr = a;
    q.push_back('{data: exp_d, err: 1'b0});
    cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    chk({tag, "_wr_bank"},   32'(wr_bank),   32'd0);
    chk({tag, "_bank_done"}, 32'(bank_done), 32'd0);
    chk({tag, "_full"},      32'(full),      32'd0);
    chk({tag, "_wr_ready"},  32'(wr_ready),  32'd1);
    chk({tag, "_rd_data"},   rd_data,        32'd0);
    chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    chk({tag, "_rd_err"},    32'(rd_err),    32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rewind = 1'b0;
    rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
    d5_wr_valid = 1'b0; d5_wr_data = '0; d5_rewind = 1'b0;
    d5_rd_en = 1'b0; d5_rd_bank = '0; d5_rd_addr = '0;
    repeat (3) cyc();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc();

    // Test 1: continuous fill of 12 words, then a refused 13th
    wr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_data = 32'h10 + 32'(i);
      cyc();
      chk($sformatf("fill%0d_bank_done", i), 32'(bank_done), (i % 4 == 3) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_full", i),      32'(full),      (i == 11) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_wr_ready", i),  32'(wr_ready),  (i == 11) ? 32'd0 : 32'd1);
      chk($sformatf("fill%0d_wr_addr", i),   32'(wr_addr),   32'((i + 1) % 4));
      chk($sformatf("fill%0d_wr_bank", i),   32'(wr_bank),   (i == 11) ? 32'd2 : 32'((i + 1) / 4));
    end
    wr_data = 32'h1C;
    cyc();
    chk("w13_full", 32'(full), 32'd1);
    chk("w13_wr_addr", 32'(wr_addr), 32'd0);
    chk("w13_wr_bank", 32'(wr_bank), 32'd2);
    chk("w13_bank_done", 32'(bank_done), 32'd0);
    wr_valid = 1'b0;

    // Test 2: back-to-back reads of every location
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 4; a++)
        rd(2'(b), 2'(a), 32'h10 + 32'(4 * b + a));
    rd_en = 1'b0;
    cyc();
    cyc();
    chk("rd_hold_data", rd_data, 32'h1B);
    chk("rd_idle_valid", 32'(rd_valid), 32'd0);

    // Test 3: out-of-range bank (DEPTH=4) and address (DEPTH=5)
    rd_en = 1'b1; rd_bank = 2'd3; rd_addr = 2'd1;
    q.push_back('{data: 32'd0, err: 1'b1});
    d5_rd_en = 1'b1; d5_rd_bank = 2'd0; d5_rd_addr = 3'd5;
    q5.push_back('{data: 32'd0, err: 1'b1});
    cyc();
    rd_en = 1'b0; d5_rd_en = 1'b0;
    cyc();
    chk("err_clear", 32'(rd_err), 32'd0);
    chk("err5_clear", 32'(d5_rd_err), 32'd0);

    // Test 5: rewind with a same-cycle write while full
    rewind = 1'b1; wr_valid = 1'b1; wr_data = 32'hEE;
    cyc();
    rewind = 1'b0; wr_valid = 1'b0;
    chk("rew_full", 32'(full), 32'd0);
    chk("rew_wr_addr", 32'(wr_addr), 32'd0);
    chk("rew_wr_bank", 32'(wr_bank), 32'd0);
    chk("rew_wr_ready", 32'(wr_ready), 32'd1);
    rd(2'd0, 2'd0, 32'h10);
    rd(2'd2, 2'd3, 32'h1B);
    rd_en = 1'b0;

    // Test 4: read-before-write on the same location
    wr_valid = 1'b1; wr_data = 32'hAA;
    cyc();
    wr_valid = 1'b0; rewind = 1'b1;
    cyc();
    rewind = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hBB;
    rd(2'd0, 2'd0, 32'hAA);
    wr_valid = 1'b0;
    rd(2'd0, 2'd0, 32'hBB);
    rd_en = 1'b0;
    chk("rbw_wr_addr", 32'(wr_addr), 32'd1);

    // Test 6: asynchronous reset mid-fill
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 32'h50 + 32'(i);
      cyc();
    end
    chk("mid_wr_bank", 32'(wr_bank), 32'd1);
    chk("mid_wr_addr", 32'(wr_addr), 32'd2);
    wr_data = 32'h55;
    rd(2'd0, 2'd1, 32'h50);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    cyc();
    cyc();
    chk("inrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("inrst_rd_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b0; wr_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    wr_valid = 1'b1; wr_data = 32'hCC;
    cyc();
    wr_valid = 1'b0;
    chk("post_wr_addr", 32'(wr_addr), 32'd1);
    chk("post_wr_bank", 32'(wr_bank), 32'd0);
    rd(2'd0, 2'd0, 32'hCC);
    rd_en = 1'b0;
    cyc();
    cyc();

    chk("sb_drained", 32'(q.size()), 32'd0);
    chk("sb5_drained", 32'(q5.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
